// File: rtl/fp_pkg.sv
// ------------------------------------------------------------------
// fp_pkg: shared widths, field helpers and special-case tag type
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package fp_pkg;

  localparam int DEF_EXP_W  = 8;
  localparam int DEF_MAN_W  = 23;
  localparam int DEF_DATA_W = 1 + DEF_EXP_W + DEF_MAN_W;

  // Helpers work on a wide container so any EXP_W/MAN_W up to 64 bits fits
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_QNAN = 2'd1,
    TAG_INF  = 2'd2,
    TAG_ZERO = 2'd3
  } tag_e;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [MAX_W-1:0] qnan_word(input int exp_w, input int man_w);
    logic [MAX_W-1:0] w;
    w = ((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w;
    w = w | (MAX_W'(1) << (man_w - 1));
    return w;
  endfunction

  function automatic logic get_sign(input logic [MAX_W-1:0] x, input int exp_w, input int man_w);
    logic [MAX_W-1:0] t;
    t = x >> (exp_w + man_w);
    return t[0];
  endfunction

  function automatic logic [MAX_W-1:0] get_exp(input logic [MAX_W-1:0] x, input int exp_w, input int man_w);
    return (x >> man_w) & ((MAX_W'(1) << exp_w) - MAX_W'(1));
  endfunction

  function automatic logic [MAX_W-1:0] get_man(input logic [MAX_W-1:0] x, input int man_w);
    return x & ((MAX_W'(1) << man_w) - MAX_W'(1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_lzc.sv
// ------------------------------------------------------------------
// fp_lzc: combinational leading-zero counter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fp_lzc #(
  parameter int WIDTH = 28,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] count
);

  logic found;

  // An all-zero input yields a don't-care count; callers detect zero separately
  always_comb begin
    count = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (din[i]) found = 1'b1;
        else        count = count + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
// ------------------------------------------------------------------
// fp_addsub_pipe: pipelined floating-point add/subtract, RNE rounding
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  localparam int DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_valid,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags
);

  localparam int MW       = MAN_W + 1;
  localparam int YW       = MAN_W + 4;
  localparam int SW       = MAN_W + 5;
  localparam int LZW      = $clog2(SW);
  localparam int SH_MAX   = MAN_W + 3;
  localparam int EXP_ALL1 = (1 << EXP_W) - 1;
  localparam logic [DATA_W-1:0] QNAN = DATA_W'(qnan_word(EXP_W, MAN_W));

  // input capture
  logic              s0_valid, s0_op;
  logic [DATA_W-1:0] s0_a, s0_b;

  // stage 1: classify, swap, exponent difference
  logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb, ma_raw, mb_raw;
  tag_e             tag1;
  logic             sign1, inv1;

  always_comb begin
    sa     = get_sign(MAX_W'(s0_a), EXP_W, MAN_W);
    sb     = get_sign(MAX_W'(s0_b), EXP_W, MAN_W) ^ s0_op;
    ea     = EXP_W'(get_exp(MAX_W'(s0_a), EXP_W, MAN_W));
    eb     = EXP_W'(get_exp(MAX_W'(s0_b), EXP_W, MAN_W));
    ma_raw = MAN_W'(get_man(MAX_W'(s0_a), MAN_W));
    mb_raw = MAN_W'(get_man(MAX_W'(s0_b), MAN_W));
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    ma     = a_zero ? '0 : ma_raw;
    mb     = b_zero ? '0 : mb_raw;
    a_inf  = (ea == '1) && (ma == '0);
    b_inf  = (eb == '1) && (mb == '0);
    a_nan  = (ea == '1) && (ma != '0);
    b_nan  = (eb == '1) && (mb != '0);
    a_ge   = (ea > eb) || ((ea == eb) && (ma >= mb));
    tag1   = TAG_NONE;
    inv1   = 1'b0;
    sign1  = a_ge ? sa : sb;
    if (a_nan || b_nan) begin
      tag1 = TAG_QNAN;
    end else if (a_inf && b_inf && (sa != sb)) begin
      tag1 = TAG_QNAN;
      inv1 = 1'b1;
    end else if (a_inf) begin
      tag1  = TAG_INF;
      sign1 = sa;
    end else if (b_inf) begin
      tag1  = TAG_INF;
      sign1 = sb;
    end else if (a_zero && b_zero) begin
      tag1  = TAG_ZERO;
      sign1 = sa & sb;
    end
  end

  logic             s1_valid, s1_sign, s1_inv, s1_sub;
  tag_e             s1_tag;
  logic [EXP_W-1:0] s1_ex, s1_d;
  logic [MW-1:0]    s1_mx, s1_my;

  // stage 2: align Y with guard/round/sticky
  int            sh2;
  logic [YW-1:0] wide2, ysh2;
  logic          lost2;

  always_comb begin
    sh2   = (int'(s1_d) > SH_MAX) ? SH_MAX : int'(s1_d);
    wide2 = {s1_my, 3'b000};
    lost2 = 1'b0;
    for (int i = 0; i < YW; i++) begin
      if (i < sh2) lost2 = lost2 | wide2[i];
    end
    ysh2    = wide2 >> sh2;
    ysh2[0] = ysh2[0] | lost2;
  end

  logic             s2_valid, s2_sign, s2_inv, s2_sub;
  tag_e             s2_tag;
  logic [EXP_W-1:0] s2_ex;
  logic [MW-1:0]    s2_mx;
  logic [YW-1:0]    s2_ysh;

  // stage 3: mantissa add/subtract and leading-zero count
  logic [SW-1:0]  xe3, ye3, sum3;
  logic [LZW-1:0] lz3;

  always_comb begin
    xe3  = {1'b0, s2_mx, 3'b000};
    ye3  = {1'b0, s2_ysh};
    sum3 = s2_sub ? (xe3 - ye3) : (xe3 + ye3);
  end

  fp_lzc #(.WIDTH(SW)) u_lzc (
    .din   (sum3),
    .count (lz3)
  );

  logic             s3_valid, s3_sign, s3_inv;
  tag_e             s3_tag;
  logic [EXP_W-1:0] s3_ex;
  logic [SW-1:0]    s3_sum;
  logic [LZW-1:0]   s3_lz;

  // stage 4: normalise, round to nearest even, pack
  int                 sh4, e4;
  logic [YW-1:0]      n4;
  logic               rnd4;
  logic [MAN_W+1:0]   mr4;
  logic [MAN_W-1:0]   mant4;
  logic [DATA_W-1:0]  res4;
  logic [2:0]         flags4;

  always_comb begin
    sh4 = 0;
    e4  = 0;
    n4  = '0;
    if (s3_sum[SW-1]) begin
      n4    = s3_sum[SW-1:1];
      n4[0] = s3_sum[1] | s3_sum[0];
      e4    = int'(s3_ex) + 1;
    end else begin
      sh4 = int'(s3_lz) - 1;
      if (sh4 < 0) sh4 = 0;
      n4  = s3_sum[YW-1:0] << sh4;
      e4  = int'(s3_ex) - sh4;
    end
    rnd4 = n4[2] & (n4[3] | n4[1] | n4[0]);
    mr4  = {1'b0, n4[YW-1:3]} + (MAN_W+2)'(rnd4);
    if (mr4[MAN_W+1]) begin
      e4    = e4 + 1;
      mant4 = mr4[MAN_W:1];
    end else begin
      mant4 = mr4[MAN_W-1:0];
    end
    res4   = '0;
    flags4 = 3'b000;
    case (s3_tag)
      TAG_QNAN: begin
        res4   = QNAN;
        flags4 = {s3_inv, 2'b00};
      end
      TAG_INF:  res4 = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      TAG_ZERO: res4 = {s3_sign, {(DATA_W-1){1'b0}}};
      default: begin
        if (s3_sum == '0) begin
          res4 = '0;
        end else if (e4 >= EXP_ALL1) begin
          res4   = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags4 = 3'b010;
        end else if (e4 < 1) begin
          res4   = {s3_sign, {(DATA_W-1){1'b0}}};
          flags4 = 3'b001;
        end else begin
          res4 = {s3_sign, EXP_W'(e4), mant4};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0; s0_op <= 1'b0; s0_a <= '0; s0_b <= '0;
      s1_valid <= 1'b0; s1_sign <= 1'b0; s1_inv <= 1'b0; s1_sub <= 1'b0;
      s1_tag <= TAG_NONE; s1_ex <= '0; s1_d <= '0; s1_mx <= '0; s1_my <= '0;
      s2_valid <= 1'b0; s2_sign <= 1'b0; s2_inv <= 1'b0; s2_sub <= 1'b0;
      s2_tag <= TAG_NONE; s2_ex <= '0; s2_mx <= '0; s2_ysh <= '0;
      s3_valid <= 1'b0; s3_sign <= 1'b0; s3_inv <= 1'b0;
      s3_tag <= TAG_NONE; s3_ex <= '0; s3_sum <= '0; s3_lz <= '0;
      out_valid <= 1'b0; result <= '0; flags <= 3'b000;
    end else if (ena) begin
      s0_valid <= in_valid;
      s0_op    <= op;
      s0_a     <= a;
      s0_b     <= b;

      s1_valid <= s0_valid;
      s1_sign  <= sign1;
      s1_inv   <= inv1;
      s1_tag   <= tag1;
      s1_sub   <= sa ^ sb;
      s1_ex    <= a_ge ? ea : eb;
      s1_d     <= a_ge ? (ea - eb) : (eb - ea);
      s1_mx    <= a_ge ? {~a_zero, ma} : {~b_zero, mb};
      s1_my    <= a_ge ? {~b_zero, mb} : {~a_zero, ma};

      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_inv   <= s1_inv;
      s2_tag   <= s1_tag;
      s2_sub   <= s1_sub;
      s2_ex    <= s1_ex;
      s2_mx    <= s1_mx;
      s2_ysh   <= ysh2;

      s3_valid <= s2_valid;
      s3_sign  <= s2_sign;
      s3_inv   <= s2_inv;
      s3_tag   <= s2_tag;
      s3_ex    <= s2_ex;
      s3_sum   <= sum3;
      s3_lz    <= lz3;

      // result keeps its last value across bubbles; flags do not
      out_valid <= s3_valid;
      if (s3_valid) begin
        result <= res4;
        flags  <= flags4;
      end else begin
        flags  <= 3'b000;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
// ------------------------------------------------------------------
// tb_fp_addsub_pipe: directed vectors with queue scoreboard
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_fp_addsub_pipe;

  localparam int NV = 17;

  localparam logic [31:0] VA [NV] = '{
    32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800000,
    32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001, 32'h40400000,
    32'h3F800000, 32'h00800000, 32'hFF800000, 32'h00000001, 32'hFF7FFFFF,
    32'h80000000, 32'hC0000000};
  localparam logic [31:0] VB [NV] = '{
    32'h40000000, 32'h3F800000, 32'h80000000, 32'h33800000, 32'h33800001,
    32'h33800000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h3F800000,
    32'h40000000, 32'h00800001, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF,
    32'h00000000, 32'h3F800000};
  localparam logic VOP [NV] = '{
    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [31:0] VR [NV] = '{
    32'h40400000, 32'h00000000, 32'h80000000, 32'h3F800000, 32'h3F800001,
    32'h3F800002, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h40000000,
    32'hBF800000, 32'h80000000, 32'hFF800000, 32'h3F800000, 32'hFF800000,
    32'h00000000, 32'hBF800000};
  localparam logic [2:0] VF [NV] = '{
    3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b100, 3'b000,
    3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000};

  typedef struct {
    logic [31:0] res;
    logic [2:0]  fl;
    int          tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, ena, in_valid, op;
  logic [31:0] a, b;
  logic        out_valid;
  logic [31:0] result;
  logic [2:0]  flags;

  logic [31:0] exp_res;
  logic [2:0]  exp_fl;
  exp_t        q[$];
  int          ena_edges = 0;
  logic        last_en = 1'b0;
  logic [31:0] last_res = '0;
  int          checks = 0;
  int          errors = 0;

  fp_addsub_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  task automatic set_op(input int i);
    a        = VA[i];
    b        = VB[i];
    op       = VOP[i];
    exp_res  = VR[i];
    exp_fl   = VF[i];
    in_valid = 1'b1;
  endtask

  // Stimulus side: record the expected response at the accepting edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      last_en <= 1'b0;
    end else begin
      last_en <= ena;
      if (ena) ena_edges <= ena_edges + 1;
      if (ena && in_valid) q.push_back('{exp_res, exp_fl, ena_edges + 5});
    end
  end

  // Monitor side: compare each newly presented output
  always @(negedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      last_res = '0;
    end else if (last_en) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("flags", {29'd0, flags}, {29'd0, e.fl});
          chk("latency", 32'(ena_edges), 32'(e.tick));
          last_res = result;
        end
      end else begin
        chk("bubble_hold", result, last_res);
        chk("bubble_flags", {29'd0, flags}, 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; op = 1'b0;
    a = '0; b = '0; exp_res = '0; exp_fl = '0;
    repeat (2) @(negedge clk);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {29'd0, flags}, 32'd0);
    rst_n = 1'b1;

    // back-to-back stream with a 3-cycle stall while op 4 waits at the input
    for (int i = 0; i < NV; i++) begin
      set_op(i);
      if (i == 4) begin
        ena = 1'b0;
        repeat (3) @(negedge clk);
        ena = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clk);

    // same vectors separated by bubbles
    for (int i = 0; i < NV; i++) begin
      set_op(i);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);

    // reset with four operations in flight
    for (int i = 0; i < 4; i++) begin
      set_op(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_op(0);
    @(negedge clk);
    in_valid = 1'b0;

    for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge clk);
    chk("pending_empty", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

`default_nettype wire
